// File: rtl/tagged_dispatcher_pkg.sv
// Shared sizing for the tagged dispatcher and the merge that drains its channels.
package tagged_dispatcher_pkg;

  localparam int unsigned DEF_NUM_FIFOS = 4;
  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_DEPTH     = 4;

  // Tag width for n channels, never narrower than one bit.
  function automatic int unsigned tag_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_TAGWIDTH = tag_width(DEF_NUM_FIFOS);

endpackage

// File: rtl/tagged_dispatcher_if.sv
// Tagged input stream, per-channel pop and per-channel head/status outputs.
interface tagged_dispatcher_if #(
  parameter int unsigned NUM_FIFOS = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TAGWIDTH  = 2
);
  logic                       in_vld;
  logic [WIDTH-1:0]           in_data;
  logic [TAGWIDTH-1:0]        in_tag;
  logic                       in_rdy;
  logic [NUM_FIFOS-1:0]       pop;
  logic [NUM_FIFOS*WIDTH-1:0] flat_data_out;
  logic [NUM_FIFOS-1:0]       empty;
  logic [NUM_FIFOS-1:0]       full;
  logic                       err;

  modport master (
    output in_vld, in_data, in_tag, pop,
    input  in_rdy, flat_data_out, empty, full, err
  );

  modport slave (
    input  in_vld, in_data, in_tag, pop,
    output in_rdy, flat_data_out, empty, full, err
  );
endinterface

// File: rtl/tagged_dispatcher_fifo.sv
// Circular-pointer FIFO for one destination channel; head word shown combinationally.
module tagged_dispatcher_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/tagged_dispatcher.sv
// Steers a tagged word stream through a one-entry stage into per-tag channel FIFOs.
module tagged_dispatcher
  import tagged_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned TAGWIDTH  = tag_width(NUM_FIFOS)
) (
  input logic                clk,
  input logic                rst,
  tagged_dispatcher_if.slave bus
);
  logic                       stg_vld;
  logic [WIDTH-1:0]           stg_data;
  logic [TAGWIDTH-1:0]        stg_tag;
  logic                       err;
  logic                       out_of_range;
  logic                       tag_full;
  logic                       drain;
  logic                       accept;
  logic                       in_rdy;
  logic                       pop_err;
  logic [NUM_FIFOS-1:0]       fifo_push;
  logic [NUM_FIFOS-1:0]       fifo_pop;
  logic [NUM_FIFOS-1:0]       empty;
  logic [NUM_FIFOS-1:0]       full;
  logic [WIDTH-1:0]           head [NUM_FIFOS];
  logic [NUM_FIFOS*WIDTH-1:0] flat;

  // Stage drain decision uses full as registered, so a same-cycle pop never feeds a push.
  always_comb begin
    out_of_range = (32'(stg_tag) >= 32'(NUM_FIFOS));
    tag_full     = 1'b0;
    fifo_push    = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (stg_tag == TAGWIDTH'(i)) tag_full = full[i];
    end
    drain = stg_vld & (out_of_range | ~tag_full);
    for (int i = 0; i < NUM_FIFOS; i++) begin
      fifo_push[i] = drain & (stg_tag == TAGWIDTH'(i));
    end
    in_rdy   = ~rst & (~stg_vld | drain);
    accept   = bus.in_vld & in_rdy;
    fifo_pop = bus.pop & ~empty;
    pop_err  = |(bus.pop & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld  <= 1'b0;
      stg_data <= '0;
      stg_tag  <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        stg_vld  <= 1'b1;
        stg_data <= bus.in_data;
        stg_tag  <= bus.in_tag;
      end else if (drain) begin
        stg_vld  <= 1'b0;
      end
      if ((drain & out_of_range) | pop_err) err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_chan
    tagged_dispatcher_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[i]),
      .pop   (fifo_pop[i]),
      .din   (stg_data),
      .dout  (head[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < NUM_FIFOS; i++) flat[i*WIDTH +: WIDTH] = head[i];
  end

  assign bus.in_rdy        = in_rdy;
  assign bus.flat_data_out = flat;
  assign bus.empty         = empty;
  assign bus.full          = full;
  assign bus.err           = err;
endmodule

// File: tb/tb_tagged_dispatcher.sv
// Directed bench: 4-channel dispatcher plus a 3-channel instance for out-of-range tags.
module tb_tagged_dispatcher;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  tagged_dispatcher_if #(.NUM_FIFOS(4), .WIDTH(8), .TAGWIDTH(2)) bus ();
  tagged_dispatcher_if #(.NUM_FIFOS(3), .WIDTH(8), .TAGWIDTH(2)) bus3 ();

  tagged_dispatcher #(.NUM_FIFOS(4), .WIDTH(8), .DEPTH(4), .TAGWIDTH(2)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  tagged_dispatcher #(.NUM_FIFOS(3), .WIDTH(8), .DEPTH(4), .TAGWIDTH(2)) dut3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] head(input int ch);
    return bus.flat_data_out[ch*8 +: 8];
  endfunction

  function automatic logic [7:0] head3(input int ch);
    return bus3.flat_data_out[ch*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++; if (bus.in_rdy !== 1'b0) begin fails++; $display("FAIL rst_in_rdy got=%b exp=0", bus.in_rdy); end
    rst = 1'b0;
    #1;
    tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL idle_in_rdy got=%b exp=1", bus.in_rdy); end
    tests++; if (bus.empty !== 4'b1111) begin fails++; $display("FAIL idle_empty got=%b exp=1111", bus.empty); end
    tests++; if (bus.full !== 4'b0000) begin fails++; $display("FAIL idle_full got=%b exp=0000", bus.full); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL idle_err got=%b exp=0", bus.err); end
    tests++; if (bus3.empty !== 3'b111) begin fails++; $display("FAIL idle3_empty got=%b exp=111", bus3.empty); end
  endtask

  task automatic test_single();
    bus.in_vld = 1'b1; bus.in_data = 8'hA5; bus.in_tag = 2'd2;
    tick();
    bus.in_vld = 1'b0;
    tests++; if (bus.empty !== 4'b1111) begin fails++; $display("FAIL single_staged_empty got=%b exp=1111", bus.empty); end
    tick();
    tests++; if (bus.empty !== 4'b1011) begin fails++; $display("FAIL single_empty got=%b exp=1011", bus.empty); end
    tests++; if (head(2) !== 8'hA5) begin fails++; $display("FAIL single_head2 got=%h exp=a5", head(2)); end
    bus.pop = 4'b0100;
    tick();
    bus.pop = 4'b0000;
    tests++; if (bus.empty !== 4'b1111) begin fails++; $display("FAIL single_popped_empty got=%b exp=1111", bus.empty); end
  endtask

  task automatic test_fill_stall();
    for (int k = 1; k <= 5; k++) begin
      bus.in_vld = 1'b1; bus.in_data = 8'(k); bus.in_tag = 2'd1;
      tick();
    end
    bus.in_vld = 1'b0;
    tests++; if (bus.full !== 4'b0010) begin fails++; $display("FAIL fill_full got=%b exp=0010", bus.full); end
    tests++; if (bus.in_rdy !== 1'b0) begin fails++; $display("FAIL fill_stall_rdy got=%b exp=0", bus.in_rdy); end
    tests++; if (head(1) !== 8'h01) begin fails++; $display("FAIL fill_head1 got=%h exp=01", head(1)); end
    bus.pop = 4'b0010;
    tick();
    bus.pop = 4'b0000;
    tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL fill_unstall_rdy got=%b exp=1", bus.in_rdy); end
    tests++; if (bus.full !== 4'b0000) begin fails++; $display("FAIL fill_after_pop_full got=%b exp=0000", bus.full); end
    tick();
    tests++; if (bus.full !== 4'b0010) begin fails++; $display("FAIL fill_refull got=%b exp=0010", bus.full); end
    for (int k = 2; k <= 5; k++) begin
      tests++; if (head(1) !== 8'(k)) begin fails++; $display("FAIL fill_order got=%h exp=%h", head(1), 8'(k)); end
      bus.pop = 4'b0010;
      tick();
    end
    bus.pop = 4'b0000;
    tests++; if (bus.empty !== 4'b1111) begin fails++; $display("FAIL fill_drained got=%b exp=1111", bus.empty); end
  endtask

  task automatic test_interleaved();
    logic [1:0] tags [4];
    logic [7:0] data [4];
    tags = '{2'd0, 2'd3, 2'd0, 2'd3};
    data = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      bus.in_vld = 1'b1; bus.in_data = data[k]; bus.in_tag = tags[k];
      tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL inter_rdy got=%b exp=1 word=%0d", bus.in_rdy, k); end
      tick();
    end
    bus.in_vld = 1'b0;
    tick();
    tests++; if (head(0) !== 8'h11) begin fails++; $display("FAIL inter_ch0_first got=%h exp=11", head(0)); end
    tests++; if (head(3) !== 8'h22) begin fails++; $display("FAIL inter_ch3_first got=%h exp=22", head(3)); end
    bus.pop = 4'b1001;
    tick();
    tests++; if (head(0) !== 8'h33) begin fails++; $display("FAIL inter_ch0_second got=%h exp=33", head(0)); end
    tests++; if (head(3) !== 8'h44) begin fails++; $display("FAIL inter_ch3_second got=%h exp=44", head(3)); end
    tick();
    bus.pop = 4'b0000;
    tests++; if (bus.empty !== 4'b1111) begin fails++; $display("FAIL inter_drained got=%b exp=1111", bus.empty); end
  endtask

  task automatic test_hol_block();
    for (int k = 0; k < 5; k++) begin
      bus.in_vld = 1'b1; bus.in_data = 8'hA0 + 8'(k); bus.in_tag = 2'd0;
      tick();
    end
    bus.in_data = 8'hC1; bus.in_tag = 2'd1;
    for (int k = 0; k < 3; k++) begin
      tests++; if (bus.in_rdy !== 1'b0) begin fails++; $display("FAIL hol_rdy got=%b exp=0 cyc=%0d", bus.in_rdy, k); end
      tick();
    end
    tests++; if (bus.empty[1] !== 1'b1) begin fails++; $display("FAIL hol_ch1_blocked got=%b exp=1", bus.empty[1]); end
    bus.pop = 4'b0001;
    tick();
    bus.pop = 4'b0000;
    tick();
    bus.in_vld = 1'b0;
    tests++; if (bus.empty[1] !== 1'b1) begin fails++; $display("FAIL hol_ch1_staged got=%b exp=1", bus.empty[1]); end
    tick();
    tests++; if (bus.empty[1] !== 1'b0) begin fails++; $display("FAIL hol_ch1_written got=%b exp=0", bus.empty[1]); end
    tests++; if (head(1) !== 8'hC1) begin fails++; $display("FAIL hol_ch1_head got=%h exp=c1", head(1)); end
    tests++; if (head(0) !== 8'hA1) begin fails++; $display("FAIL hol_ch0_head got=%h exp=a1", head(0)); end
    bus.pop = 4'b0011;
    tick();
    bus.pop = 4'b0001;
    tick(); tick();
    tests++; if (head(0) !== 8'hA4) begin fails++; $display("FAIL hol_ch0_last got=%h exp=a4", head(0)); end
    tick();
    bus.pop = 4'b0000;
    tests++; if (bus.empty !== 4'b1111) begin fails++; $display("FAIL hol_drained got=%b exp=1111", bus.empty); end
  endtask

  task automatic test_errors();
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL err_clean got=%b exp=0", bus.err); end
    bus.pop = 4'b1000;
    tick();
    bus.pop = 4'b0000;
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL err_pop_empty got=%b exp=1", bus.err); end
    tests++; if (bus.empty !== 4'b1111) begin fails++; $display("FAIL err_pop_empty_state got=%b exp=1111", bus.empty); end
    tick(); tick();
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL err_sticky got=%b exp=1", bus.err); end
    tests++; if (bus3.err !== 1'b0) begin fails++; $display("FAIL err3_clean got=%b exp=0", bus3.err); end
    bus3.in_vld = 1'b1; bus3.in_data = 8'h77; bus3.in_tag = 2'd3;
    tick();
    bus3.in_vld = 1'b0;
    tick();
    tests++; if (bus3.err !== 1'b1) begin fails++; $display("FAIL err3_bad_tag got=%b exp=1", bus3.err); end
    tests++; if (bus3.empty !== 3'b111) begin fails++; $display("FAIL err3_dropped got=%b exp=111", bus3.empty); end
    tests++; if (bus3.in_rdy !== 1'b1) begin fails++; $display("FAIL err3_rdy got=%b exp=1", bus3.in_rdy); end
    bus3.in_vld = 1'b1; bus3.in_data = 8'h5A; bus3.in_tag = 2'd2;
    tick();
    bus3.in_vld = 1'b0;
    tick();
    tests++; if (bus3.empty !== 3'b011) begin fails++; $display("FAIL err3_valid_empty got=%b exp=011", bus3.empty); end
    tests++; if (head3(2) !== 8'h5A) begin fails++; $display("FAIL err3_valid_head got=%h exp=5a", head3(2)); end
  endtask

  task automatic test_reset_midop();
    bus.in_vld = 1'b1; bus.in_data = 8'h3C; bus.in_tag = 2'd0;
    tick(); tick();
    bus.in_vld = 1'b0;
    tests++; if (bus.empty[0] !== 1'b0) begin fails++; $display("FAIL midop_loaded got=%b exp=0", bus.empty[0]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tests++; if (bus.empty !== 4'b1111) begin fails++; $display("FAIL midop_empty got=%b exp=1111", bus.empty); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL midop_err got=%b exp=0", bus.err); end
    tests++; if (bus3.err !== 1'b0) begin fails++; $display("FAIL midop_err3 got=%b exp=0", bus3.err); end
    tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL midop_rdy got=%b exp=1", bus.in_rdy); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.in_vld  = 1'b0; bus.in_data  = '0; bus.in_tag  = '0; bus.pop  = '0;
    bus3.in_vld = 1'b0; bus3.in_data = '0; bus3.in_tag = '0; bus3.pop = '0;
    test_reset();
    test_single();
    test_fill_stall();
    test_interleaved();
    test_hol_block();
    test_errors();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
